hclk_meas_sched: RTL and testbench
==================================

Name: hclk_meas_sched

Overview:
- Controller that sequences the bank of NUM_HCLK divided-clock channels (CLKDIV2 followed by CLKDIV, one channel per HCLK).
- For one channel at a time it pulses that channel's divider reset, waits for the divider to settle, then counts toggles of the channel's divided-domain toggle bit over a fixed gate window of `clk` cycles and reports the count.
- It then advances to the next channel and wraps after the last one.
- It sits in the `clk` domain. It replaces the free-running index rotation with measured, deterministic channel scheduling. `sel_idx` drives the LED mux.

Parameters:
- NUM_HCLK, 4: number of divider channels (at least 1).
- RST_CYCLES, 16: clk cycles that div_resetn[idx] is held low (at least 1).
- SETTLE_CYCLES, 64: clk cycles after reset release before counting (at least 1).
- GATE_LOG2, 16: the gate window is 2**GATE_LOG2 clk cycles.
- CNT_W, 24: width of the measurement counter. It saturates.

Ports:
- clk  in  1  system clock; the same clock that feeds the CLKDIV2 HCLKIN inputs
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable, level-sensitive
- div_tog  in  NUM_HCLK  per-channel toggle bit from the divided domain (for example count[0]); asynchronous to clk
- div_resetn  out  NUM_HCLK  per-channel CLKDIV2 RESETN; active-low
- sel_idx  out  clog2(NUM_HCLK) (minimum 1)  channel currently being scheduled
- busy  out  1  high in every state except IDLE
- meas_valid  out  1  one-cycle pulse when a measurement completes
- meas_idx  out  clog2(NUM_HCLK) (minimum 1)  channel of the last measurement
- meas_count  out  CNT_W  edge count of the last measurement
- sweep_done  out  1  pulses together with meas_valid when meas_idx equals NUM_HCLK-1

Behaviour:
- Reset values: state IDLE; sel_idx=0; div_resetn all 1; busy=0; meas_valid=0; sweep_done=0; meas_idx=0; meas_count=0; all synchronizers and edge history at 0.
- Every div_tog bit passes through its own 2-FF synchronizer. The synchronized bit of channel sel_idx is selected. Edge detection compares it with a one-register history; either edge (rising or falling) counts as one edge.
- FSM states: IDLE, RESET, SETTLE, GATE, REPORT. A single down-counter, sized for the largest of RST_CYCLES, SETTLE_CYCLES and 2**GATE_LOG2, times each state.
- IDLE: if en=1, go to RESET on the next cycle.
- RESET: lasts exactly RST_CYCLES cycles. div_resetn[sel_idx]=0 in these cycles; all other bits stay 1. Then go to SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. No counting. The edge history is loaded every cycle, so the mux switch and reset glitch never produce a counted edge. The edge counter is cleared on the last SETTLE cycle.
- GATE: lasts exactly 2**GATE_LOG2 cycles. The counter increments on each detected edge and holds at 2**CNT_W-1; it does not wrap.
- REPORT: lasts 1 cycle.
  - meas_valid=1, meas_idx=sel_idx, meas_count=counter.
  - sweep_done=1 if sel_idx equals NUM_HCLK-1.
  - sel_idx becomes sel_idx+1, or 0 when sel_idx equals NUM_HCLK-1.
  - Next state is RESET if en=1, otherwise IDLE.
- meas_idx and meas_count hold their values until the next REPORT.
- Latency: if en is first sampled high in IDLE at cycle t, meas_valid is asserted at cycle t+1+RST_CYCLES+SETTLE_CYCLES+2**GATE_LOG2.
- en deasserted mid-measurement: the current measurement completes and reports; the FSM stops in IDLE with sel_idx already advanced.
- rst mid-operation: on the next edge everything returns to reset values. No meas_valid is issued for the aborted measurement, and div_resetn returns to all 1.
- NUM_HCLK=1: sel_idx stays 0, and sweep_done accompanies every meas_valid.

Decomposition:
- Shared package hclk_meas_pkg holds:
  - the state enum: IDLE, RESET, SETTLE, GATE, REPORT;
  - the index-width function, max(1, clog2(NUM_HCLK));
  - the timer-width function.
- One sub-module, tog_sync_edge, holds the 2-FF synchronizer for one bit. It is instantiated NUM_HCLK times. Edge history and counting stay in the top module.

Test Plan (GATE_LOG2=8, RST_CYCLES=4, SETTLE_CYCLES=8, CNT_W=16, NUM_HCLK=4):
- rst, then en=1 at cycle t. Channel 0 toggles every 2 clk.
  - div_resetn=4'b1110 for cycles t+1..t+4.
  - meas_valid at t+1+4+8+256 = t+269, with meas_idx=0 and meas_count=128 ±1.
- Channels toggle every 2, 7, 8 and 10 clk, en held high.
  - meas_count is 128, 36/37, 32 and 25/26 ±1 in that order.
  - sweep_done pulses with idx 3; sel_idx wraps to 0 and channel 0 is measured again.
- CNT_W=4, channel toggling every 2 clk → meas_count=15 (saturated, not wrapped).
- en dropped during GATE of channel 1 → that measurement reports normally, the FSM goes to IDLE, busy=0, sel_idx=2, and no further meas_valid appears. Re-asserting en starts a measurement of channel 2.
- rst asserted during SETTLE of channel 2 → next cycle: state IDLE, sel_idx=0, div_resetn=4'b1111, meas_count=0, and no meas_valid.
- A channel with div_tog stuck at 1 across the mux switch → meas_count=0; no spurious edge is counted.

Source files
------------

// File: rtl/hclk_meas_pkg.sv
// Shared types and sizing helpers for the
// divided-clock measurement scheduler.
package hclk_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    SETTLE,
    GATE,
    REPORT
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmr_w(
    input int r,
    input int s,
    input int g
  );
    int m;
    m = r;
    if (s > m) m = s;
    if ((1 << g) > m) m = 1 << g;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/hclk_meas_sched_if.sv
// Control/measurement bundle between the
// scheduler and its user.
interface hclk_meas_sched_if #(
  parameter int NUM_HCLK = 4,
  parameter int CNT_W    = 24
);
  import hclk_meas_pkg::*;

  localparam int IW = idx_w(NUM_HCLK);

  logic                en;
  logic [NUM_HCLK-1:0] div_tog;
  logic [NUM_HCLK-1:0] div_resetn;
  logic [IW-1:0]       sel_idx;
  logic                busy;
  logic                meas_valid;
  logic [IW-1:0]       meas_idx;
  logic [CNT_W-1:0]    meas_count;
  logic                sweep_done;

  modport master (
    output en, div_tog,
    input  div_resetn, sel_idx, busy,
    input  meas_valid, meas_idx,
    input  meas_count, sweep_done
  );

  modport slave (
    input  en, div_tog,
    output div_resetn, sel_idx, busy,
    output meas_valid, meas_idx,
    output meas_count, sweep_done
  );

endinterface

// File: rtl/hclk_meas_sched_tog_sync_edge.sv
// Two-flop synchronizer bringing one divided-domain
// toggle bit into the clk domain.
module tog_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the async bit through two stages
  always_comb sync_d = {sync_q[0], d};

  // synchronizer flops
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/hclk_meas_sched.sv
// Sequences divider channels: reset, settle,
// count toggle edges over a gate, report.
module hclk_meas_sched
  import hclk_meas_pkg::*;
#(
  parameter int NUM_HCLK      = 4,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_LOG2     = 16,
  parameter int CNT_W         = 24
) (
  input logic clk,
  input logic rst,
  hclk_meas_sched_if.slave bus
);

  localparam int IW = idx_w(NUM_HCLK);
  localparam int TW = tmr_w(
    RST_CYCLES, SETTLE_CYCLES, GATE_LOG2);

  localparam logic [TW-1:0] T_RST =
    TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_SET =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_GATE =
    TW'((1 << GATE_LOG2) - 1);
  localparam logic [IW-1:0] LAST =
    IW'(NUM_HCLK - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic                hist_q, hist_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mv_q, mv_d;
  logic                sw_q, sw_d;
  logic [IW-1:0]       midx_q, midx_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;
  logic [NUM_HCLK-1:0] tog_s;
  logic                tog_sel;
  logic                edge_det;

  for (genvar i = 0; i < NUM_HCLK; i++) begin
    : g_sync
    tog_sync_edge u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.div_tog[i]),
      .q   (tog_s[i])
    );
  end

  assign tog_sel  = tog_s[sel_q];
  assign edge_det = tog_sel ^ hist_q;

  // next-state, timer, edge counter and report
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    hist_d  = tog_sel;
    cnt_d   = cnt_q;
    mv_d    = 1'b0;
    sw_d    = 1'b0;
    midx_d  = midx_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RESET;
          tmr_d   = T_RST;
        end
      end
      RESET: begin
        if (tmr_q == '0) begin
          state_d = SETTLE;
          tmr_d   = T_SET;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = T_GATE;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GATE: begin
        if (edge_det && cnt_q != CMAX)
          cnt_d = cnt_q + CNT_W'(1);
        if (tmr_q == '0) begin
          state_d = REPORT;
          mv_d    = 1'b1;
          midx_d  = sel_q;
          mcnt_d  = cnt_d;
          sw_d    = (sel_q == LAST);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      REPORT: begin
        sel_d = (sel_q == LAST) ?
          '0 : sel_q + IW'(1);
        if (bus.en) begin
          state_d = RESET;
          tmr_d   = T_RST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      sel_q   <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      sw_q    <= 1'b0;
      midx_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      sw_q    <= sw_d;
      midx_q  <= midx_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign bus.div_resetn = (state_q == RESET) ?
    ~(NUM_HCLK'(1) << sel_q) : '1;
  assign bus.sel_idx    = sel_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.meas_valid = mv_q;
  assign bus.meas_idx   = midx_q;
  assign bus.meas_count = mcnt_q;
  assign bus.sweep_done = sw_q;

endmodule

// File: tb/tb_hclk_meas_sched.sv
// Scoreboard bench: a 4-channel instance and a
// 1-channel saturating instance.
module tb_hclk_meas_sched;

  typedef struct {
    int     idx;
    int     cnt;
    int     tol;
    int     sw;
    longint cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [3:0] tog;
  logic       togb;
  int         per [4];
  int         pc  [4];
  int         pcb;
  longint     cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       qa [$];
  exp_t       qb [$];
  exp_t       ea, eb;
  longint     t, t2, t3;
  int         expc [4] = '{128, 37, 32, 26};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hclk_meas_sched_if #(
    .NUM_HCLK(4), .CNT_W(16)) ifa ();
  hclk_meas_sched_if #(
    .NUM_HCLK(1), .CNT_W(4)) ifb ();

  assign ifa.en      = en_a;
  assign ifa.div_tog = tog;
  assign ifb.en      = en_b;
  assign ifb.div_tog = togb;

  hclk_meas_sched #(
    .NUM_HCLK(4), .RST_CYCLES(4),
    .SETTLE_CYCLES(8), .GATE_LOG2(8),
    .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  hclk_meas_sched #(
    .NUM_HCLK(1), .RST_CYCLES(4),
    .SETTLE_CYCLES(8), .GATE_LOG2(8),
    .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic chk(
    input string  tag,
    input longint obs,
    input longint exp,
    input longint tol = 0
  );
    longint d;
    checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d tol %0d",
        tag, obs, exp, tol);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((qa.size() + qb.size()) != 0 &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  // toggle generators, per==0 holds the bit
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (per[i] != 0) begin
          pc[i]++;
          if (pc[i] >= per[i]) begin
            pc[i]  = 0;
            tog[i] = ~tog[i];
          end
        end
      end
      pcb++;
      if (pcb >= 2) begin
        pcb  = 0;
        togb = ~togb;
      end
    end
  end

  // scoreboard compare on every reported result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ifa.meas_valid) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          ea = qa.pop_front();
          chk("a_idx", ifa.meas_idx, ea.idx);
          chk("a_cnt", ifa.meas_count,
              ea.cnt, ea.tol);
          chk("a_sweep", ifa.sweep_done, ea.sw);
          chk("a_cyc", cyc, ea.cyc);
        end
      end
      if (ifb.meas_valid) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          eb = qb.pop_front();
          chk("b_idx", ifb.meas_idx, eb.idx);
          chk("b_cnt", ifb.meas_count,
              eb.cnt, eb.tol);
          chk("b_sweep", ifb.sweep_done, eb.sw);
          chk("b_cyc", cyc, eb.cyc);
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    tog  = 4'b0;
    togb = 1'b0;
    pcb  = 0;
    for (int i = 0; i < 4; i++) begin
      per[i] = 0;
      pc[i]  = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_sel", ifa.sel_idx, 0);
    chk("rst_rstn", ifa.div_resetn, 4'hf);
    chk("rst_valid", ifa.meas_valid, 0);
    chk("rst_midx", ifa.meas_idx, 0);
    chk("rst_mcnt", ifa.meas_count, 0);
    chk("rst_sweep", ifa.sweep_done, 0);
    chk("rst_b_busy", ifb.busy, 0);

    per[0] = 2;
    per[1] = 7;
    per[2] = 8;
    per[3] = 10;
    @(negedge clk);
    t    = cyc;
    en_a = 1'b1;
    en_b = 1'b1;
    for (int k = 0; k < 5; k++)
      qa.push_back('{k % 4, expc[k % 4], 1,
        (k % 4 == 3) ? 1 : 0,
        t + 269 * (k + 1)});
    qb.push_back('{0, 15, 0, 1, t + 269});
    @(negedge clk);
    en_b = 1'b0;
    chk("rstn_ch0", ifa.div_resetn, 4'b1110);
    chk("busy_run", ifa.busy, 1);
    repeat (3) @(negedge clk);
    chk("rstn_ch0_end", ifa.div_resetn, 4'b1110);
    @(negedge clk);
    chk("rstn_release", ifa.div_resetn, 4'hf);

    repeat (int'(t + 269 * 5 + 50 - cyc))
      @(negedge clk);
    en_a = 1'b0;
    qa.push_back('{1, 37, 1, 0, t + 269 * 6});
    wait_drain(2000);
    repeat (20) @(negedge clk);
    chk("stop_busy", ifa.busy, 0);
    chk("stop_sel", ifa.sel_idx, 2);
    repeat (300) @(negedge clk);

    t2   = cyc;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    chk("restart_sel", ifa.sel_idx, 2);
    chk("rstn_ch2", ifa.div_resetn, 4'b1011);
    repeat (6) @(negedge clk);
    chk("settle_busy", ifa.busy, 1);
    chk("settle_rstn", ifa.div_resetn, 4'hf);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_sel", ifa.sel_idx, 0);
    chk("abort_rstn", ifa.div_resetn, 4'hf);
    chk("abort_mcnt", ifa.meas_count, 0);
    chk("abort_valid", ifa.meas_valid, 0);
    repeat (400) @(negedge clk);

    per[0] = 0;
    tog[0] = 1'b1;
    repeat (5) @(negedge clk);
    t3   = cyc;
    en_a = 1'b1;
    qa.push_back('{0, 0, 0, 0, t3 + 269});
    @(negedge clk);
    en_a = 1'b0;
    wait_drain(400);
    repeat (10) @(negedge clk);
    chk("end_busy", ifa.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
